button_conditioner: RTL and testbench

//  Input-side counterpart of the board LED path: turns raw asynchronous, bouncing push-button

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/button_debounce_bit.sv | 143 ++++++++++++++
 rtl/button_conditioner.sv | 43 ++++
 tb/tb_button_conditioner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types, default timing constants and sizing helper for the button conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PEND_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    PEND_RELEASE = 2'd3
  } btn_state_e;

  // 12 MHz board clock; 10 ms debounce window; 500 ms long-press threshold.
  localparam int unsigned DEFAULT_CLK_HZ          = 12_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = DEFAULT_CLK_HZ / 100;
  localparam int unsigned DEFAULT_LONG_CYCLES     = DEFAULT_CLK_HZ / 2;

  // Counter width large enough to hold the larger of the two cycle thresholds.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One button: synchronizer chain, debounce FSM with stability counter, edge pulses.
// Optional hold counter for long-press detection under BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_debounce_bit
  import button_conditioner_pkg::*;
#(
  parameter int unsigned sync_stages_p     = 2,
  parameter int unsigned debounce_cycles_p = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned long_cycles_p     = DEFAULT_LONG_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam int unsigned     CntW    = cnt_width(debounce_cycles_p, long_cycles_p);
  localparam logic [CntW-1:0] DebLast = CntW'(debounce_cycles_p - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic [sync_stages_p-1:0] sync_q;
  logic                     sync_c;
  btn_state_e               state_q;
  logic [CntW-1:0]          cnt_q;
  logic [CntW-1:0]          cnt_d;
  logic                     pressed_q;
  logic                     press_q;
  logic                     release_q;
  logic                     press_acc_c;
  logic                     release_acc_c;

  // Metastability synchronizer; shifts the raw level toward sync_c.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages_p-2:0], btn_i};
    end
  end

  assign sync_c = sync_q[sync_stages_p-1];

  // Saturating increment of the stability counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // A change is accepted on the cycle the window fills with the new value still present.
  assign press_acc_c   = (state_q == PEND_PRESS)   &&  sync_c && (cnt_q == DebLast);
  assign release_acc_c = (state_q == PEND_RELEASE) && !sync_c && (cnt_q == DebLast);

  // Debounce FSM; pulses and level are registered alongside the state change.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync_c) begin
            state_q <= PEND_PRESS;
            cnt_q   <= CntW'(1);
          end
        end
        PEND_PRESS: begin
          if (!sync_c) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (press_acc_c) begin
            state_q   <= PRESSED;
            cnt_q     <= '0;
            pressed_q <= 1'b1;
            press_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        PRESSED: begin
          if (!sync_c) begin
            state_q <= PEND_RELEASE;
            cnt_q   <= CntW'(1);
          end
        end
        PEND_RELEASE: begin
          if (sync_c) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (release_acc_c) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam logic [CntW-1:0] HoldLast = CntW'(long_cycles_p - 1);

  logic [CntW-1:0] hold_q;
  logic            long_q;

  // Hold counter restarts at press acceptance, saturates at the threshold so the pulse fires once.
  always_ff @(posedge clk_i) begin
    if (reset_i || release_acc_c || press_acc_c) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else if (pressed_q && (hold_q != HoldLast)) begin
      hold_q <= hold_q + CntW'(1);
      long_q <= (hold_q == (HoldLast - CntW'(1)));
    end else begin
      long_q <= 1'b0;
    end
  end

  assign long_press_o = long_q;
`else
  assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw push-button pins into debounced levels and press/release/long-press pulses.
// Long-press detection is built only when BUTTON_CONDITIONER_LONG_PRESS_EN is defined.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned width_p           = 3,
  parameter int unsigned sync_stages_p     = 2,
  parameter int unsigned debounce_cycles_p = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          active_low_p      = 1'b0,
  parameter int unsigned long_cycles_p     = DEFAULT_LONG_CYCLES
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] button_async_unsafe_i,
  output logic [width_p-1:0] pressed_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o,
  output logic [width_p-1:0] long_press_o
);

  logic [width_p-1:0] btn_c;

  // Normalise polarity so 1 always means pressed before synchronization.
  assign btn_c = active_low_p ? ~button_async_unsafe_i : button_async_unsafe_i;

  // One independent conditioner per button.
  for (genvar i = 0; i < int'(width_p); i++) begin : g_bit
    button_debounce_bit #(
      .sync_stages_p    (sync_stages_p),
      .debounce_cycles_p(debounce_cycles_p),
      .long_cycles_p    (long_cycles_p)
    ) u_bit (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .btn_i       (btn_c[i]),
      .pressed_o   (pressed_o[i]),
      .press_o     (press_o[i]),
      .release_o   (release_o[i]),
      .long_press_o(long_press_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table of per-cycle vectors plus reset and long-press sequences.
module tb_button_conditioner;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] pins;
  logic [1:0] pressed;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] lng;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [1:0] pins;
    logic [1:0] exp_pressed;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .width_p          (2),
    .sync_stages_p    (2),
    .debounce_cycles_p(4),
    .active_low_p     (1'b0),
    .long_cycles_p    (10)
  ) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .button_async_unsafe_i(pins),
    .pressed_o            (pressed),
    .press_o              (press),
    .release_o            (rel),
    .long_press_o         (lng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Appends n identical rows: outputs expected after an edge, then inputs driven for the next one.
  task automatic add(input logic r, input logic [1:0] p, input logic [1:0] e_pd,
                     input logic [1:0] e_pr, input logic [1:0] e_rl, input int n);
    vec_t v;
    v.rst = r; v.pins = p; v.exp_pressed = e_pd; v.exp_press = e_pr; v.exp_rel = e_rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    pins     = 2'b11;

    // Reset 3 cycles with both pins held, then full 6-edge latency to press.
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    // Release both: release pulse 6 edges later, no press pulse with it.
    add(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
    // Clean bit0 press at "cycle 0", pulse at cycle 6.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    // Release bit0 after stable press.
    add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 1);
    add(1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    // Bounce 1,0,1,1,0 then steady 1: accepted only 6 edges after the last bounce.
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 6);
    add(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 3);

    foreach (vecs[i]) begin
      step();
      chk($sformatf("tbl%0d pressed", i), pressed, vecs[i].exp_pressed);
      chk($sformatf("tbl%0d press", i), press, vecs[i].exp_press);
      chk($sformatf("tbl%0d release", i), rel, vecs[i].exp_rel);
      chk($sformatf("tbl%0d long", i), lng, 2'b00);
      reset = vecs[i].rst;
      pins  = vecs[i].pins;
    end

    // Reset while bit0 is pending with cnt=3 discards progress; restart takes full latency.
    reset = 1'b1;
    pins  = 2'b00;
    step();
    chk("rst5 pressed", pressed, 2'b00);
    reset = 1'b0;
    step();
    step();
    pins = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("pend%0d press", k), press, 2'b00);
    end
    reset = 1'b1;
    step();
    chk("midrst press", press, 2'b00);
    chk("midrst pressed", pressed, 2'b00);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("restart%0d press", k), press, (k == 6) ? 2'b01 : 2'b00);
      chk($sformatf("restart%0d pressed", k), pressed, (k == 6) ? 2'b01 : 2'b00);
    end

    // Hold bit1 for 20 cycles: long-press pulse once, 9 cycles after press.
    reset = 1'b1;
    pins  = 2'b00;
    step();
    reset = 1'b0;
    pins  = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("hold%0d press", k), press, (k == 6) ? 2'b10 : 2'b00);
      chk($sformatf("hold%0d long", k), lng, (LongEn && k == 15) ? 2'b10 : 2'b00);
    end
    pins = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("hrel%0d release", k), rel, (k == 6) ? 2'b10 : 2'b00);
      chk($sformatf("hrel%0d pressed", k), pressed, (k == 6) ? 2'b00 : 2'b10);
      chk($sformatf("hrel%0d long", k), lng, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
